apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_pkg.sv | 16 +
 rtl/apb_master_if.sv | 44 ++++
 rtl/apb_master.sv | 121 ++++++++++++
 tb/tb_apb_master.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types for the APB requester: FSM state encoding and timeout counter width.
// No logic here; imported by the interface user and the top.
// Counter width bounds the largest programmable ACCESS-phase timeout.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Width of the ACCESS-phase wait counter; TIMEOUT_CYCLES must fit in it.
  localparam int unsigned TMO_CNT_W = 16;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB requester/completer signals for apb_master.
// Pure wiring, no latency.
// Flow control is valid/ready on cmd and rsp, pready stretches the APB access.
interface apb_master_if;

  // Command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;

  // Response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  // APB bus
  logic [31:0] APB_M_0_paddr;
  logic        APB_M_0_psel;
  logic        APB_M_0_penable;
  logic        APB_M_0_pwrite;
  logic [31:0] APB_M_0_pwdata;
  logic [31:0] APB_M_0_prdata;
  logic        APB_M_0_pready;
  logic        APB_M_0_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  APB_M_0_prdata, APB_M_0_pready, APB_M_0_pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output APB_M_0_paddr, APB_M_0_psel, APB_M_0_penable, APB_M_0_pwrite, APB_M_0_pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output APB_M_0_prdata, APB_M_0_pready, APB_M_0_pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  APB_M_0_paddr, APB_M_0_psel, APB_M_0_penable, APB_M_0_pwrite, APB_M_0_pwdata
  );

endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: one command in, one APB transfer, one response out.
// Latency: cmd handshake -> rsp_valid in 3 cycles minimum (SETUP, ACCESS, RESP), plus APB wait states.
// Backpressure: cmd_ready only in IDLE; response held in RESP until rsp_ready; ACCESS aborts after TIMEOUT_CYCLES.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  apb_master_if.master  bus
);

  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES);

  state_e                 state_q;
  logic                   cmd_ready_q;
  logic                   psel_q;
  logic                   penable_q;
  logic                   pwrite_q;
  logic [31:0]            paddr_q;
  logic [31:0]            pwdata_q;
  logic                   rsp_valid_q;
  logic [31:0]            rsp_rdata_q;
  logic                   rsp_err_q;
  logic                   rsp_timeout_q;
  logic [TMO_CNT_W-1:0]   tmo_cnt_q;
  logic [TMO_CNT_W-1:0]   tmo_cnt_d;

  // Wait-state count this ACCESS cycle would reach if pready stays low.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
  end

  // Transfer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            // Address/control latched here stay untouched until the next command.
            paddr_q     <= bus.cmd_addr;
            pwrite_q    <= bus.cmd_write;
            pwdata_q    <= bus.cmd_wdata;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            state_q     <= SETUP;
          end
        end

        SETUP: begin
          penable_q <= 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= ACCESS;
        end

        ACCESS: begin
          // pready wins over a timeout landing in the same cycle.
          if (bus.APB_M_0_pready) begin
            rsp_rdata_q   <= pwrite_q ? 32'd0 : bus.APB_M_0_prdata;
            rsp_err_q     <= bus.APB_M_0_pslverr;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_cnt_d == TMO_LIMIT) begin
              rsp_rdata_q   <= '0;
              rsp_err_q     <= 1'b1;
              rsp_timeout_q <= 1'b1;
              psel_q        <= 1'b0;
              penable_q     <= 1'b0;
              rsp_valid_q   <= 1'b1;
              state_q       <= RESP;
            end
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.rsp_timeout     = rsp_timeout_q;
  assign bus.APB_M_0_paddr   = paddr_q;
  assign bus.APB_M_0_psel    = psel_q;
  assign bus.APB_M_0_penable = penable_q;
  assign bus.APB_M_0_pwrite  = pwrite_q;
  assign bus.APB_M_0_pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a behavioural APB completer and a response scoreboard.
// Expected responses are queued at command issue and checked when rsp_valid appears.
// Completer modes: 0 zero-wait, 1 registered pready, 2 never ready, 3 pready/pslverr stuck high outside ACCESS.
module tb_apb_master;

  localparam int TMO = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  apb_master_if bus ();

  apb_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors = 0;
  int          checks = 0;
  exp_t        sb_q[$];
  int          c_mode = 0;
  logic [31:0] c_prd  = 32'd0;
  logic        c_serr = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural completer, updated just after each rising edge.
  initial begin
    logic pen_prev;
    logic in_acc;
    pen_prev = 1'b0;
    bus.APB_M_0_pready  = 1'b0;
    bus.APB_M_0_pslverr = 1'b0;
    bus.APB_M_0_prdata  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      in_acc = bus.APB_M_0_psel && bus.APB_M_0_penable;
      case (c_mode)
        0:       bus.APB_M_0_pready = in_acc;
        1:       bus.APB_M_0_pready = in_acc && pen_prev;
        2:       bus.APB_M_0_pready = 1'b0;
        default: bus.APB_M_0_pready = 1'b1;
      endcase
      bus.APB_M_0_pslverr = in_acc ? c_serr : (c_mode == 3);
      bus.APB_M_0_prdata  = in_acc ? c_prd : 32'hDEAD_BEEF;
      pen_prev = in_acc;
    end
  end

  // One full transfer; hold = cycles rsp_ready stays low once rsp_valid is up.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int mode, input logic [31:0] prd, input logic serr, input int hold);
    exp_t e;
    exp_t got;
    int   k;
    c_mode = mode;
    c_prd  = prd;
    c_serr = serr;
    if (mode == 2) begin
      e.rdata = 32'd0; e.err = 1'b1; e.to = 1'b1; e.lat = 2 + TMO;
    end else begin
      e.rdata = wr ? 32'd0 : prd; e.err = serr; e.to = 1'b0; e.lat = (mode == 1) ? 4 : 3;
    end
    sb_q.push_back(e);

    k = 0;
    while (!bus.cmd_ready && k < 20) begin
      step();
      k++;
    end
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.rsp_ready = (hold == 0);
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = ~addr;
    bus.cmd_write = ~wr;
    bus.cmd_wdata = ~wdata;

    for (k = 1; k <= 40 && !bus.rsp_valid; k++) begin
      if (k == 1) begin
        chk("setup_psel", bus.APB_M_0_psel, 1);
        chk("setup_penable", bus.APB_M_0_penable, 0);
        chk("busy_cmd_ready", bus.cmd_ready, 0);
      end
      if (k == 2) chk("access_penable", bus.APB_M_0_penable, 1);
      if (bus.APB_M_0_psel) begin
        chk("paddr_stable", bus.APB_M_0_paddr, addr);
        chk("pwrite_stable", bus.APB_M_0_pwrite, wr);
        chk("pwdata_stable", bus.APB_M_0_pwdata, wdata);
      end
      step();
    end

    chk("sb_size", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      chk("rsp_latency", k, got.lat);
      chk("resp_psel", bus.APB_M_0_psel, 0);
      chk("resp_penable", bus.APB_M_0_penable, 0);
      chk("rsp_rdata", bus.rsp_rdata, got.rdata);
      chk("rsp_err", bus.rsp_err, got.err);
      chk("rsp_timeout", bus.rsp_timeout, got.to);
      for (int h = 0; h < hold; h++) begin
        chk("hold_rsp_valid", bus.rsp_valid, 1);
        chk("hold_rdata", bus.rsp_rdata, got.rdata);
        chk("hold_err", bus.rsp_err, got.err);
        chk("hold_timeout", bus.rsp_timeout, got.to);
        chk("hold_cmd_ready", bus.cmd_ready, 0);
        bus.cmd_valid = (h == 1);
        bus.cmd_addr  = 32'hFFFF_0000;
        step();
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("post_cmd_ready", bus.cmd_ready, 1);
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_psel", bus.APB_M_0_psel, 0);
    chk("post_paddr_hold", bus.APB_M_0_paddr, addr);
    chk("post_pwrite_hold", bus.APB_M_0_pwrite, wr);
    step();
    chk("no_queued_cmd", bus.APB_M_0_psel, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_wdata = 32'd0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_psel", bus.APB_M_0_psel, 0);
    chk("rst_penable", bus.APB_M_0_penable, 0);
    chk("rst_pwrite", bus.APB_M_0_pwrite, 0);
    chk("rst_paddr", bus.APB_M_0_paddr, 0);
    chk("rst_pwdata", bus.APB_M_0_pwdata, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 0);
    rst = 1'b0;
    step();
    chk("first_cmd_ready", bus.cmd_ready, 1);

    run_txn(1'b1, 32'h0000_0000, 32'h0000_0003, 1, 32'h0000_0077, 1'b0, 0);
    run_txn(1'b0, 32'h0000_0000, 32'h1111_2222, 0, 32'h0000_0002, 1'b0, 0);
    run_txn(1'b0, 32'h0000_0040, 32'h0000_0000, 0, 32'h1234_5678, 1'b1, 0);
    run_txn(1'b0, 32'h0000_0100, 32'h0000_0000, 2, 32'h5555_AAAA, 1'b0, 0);
    run_txn(1'b1, 32'h8000_0010, 32'hA5A5_0001, 0, 32'h0BAD_0BAD, 1'b0, 5);
    run_txn(1'b0, 32'h0000_000C, 32'h0000_0000, 3, 32'hCAFE_F00D, 1'b0, 0);
    run_txn(1'b1, 32'h0000_0020, 32'h0000_00FF, 1, 32'h0000_1234, 1'b1, 0);

    // Reset pulse during ACCESS abandons the transfer silently.
    c_mode = 2;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_0200;
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("midrst_in_access", bus.APB_M_0_penable, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_psel", bus.APB_M_0_psel, 0);
    chk("midrst_penable", bus.APB_M_0_penable, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    step();
    step();
    step();
    chk("midrst_no_rsp", bus.rsp_valid, 0);
    run_txn(1'b0, 32'h0000_0300, 32'h0000_0000, 1, 32'h600D_600D, 1'b0, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
